// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared definitions for the systolic_array result drain.
//   - drain_state_e : drain sequencer states (IDLE / SETTLE / STREAM)
//   - settle_cycles : cycles between the arm pulse and the accumulator snapshot
//   - idx_width     : counter width helper, never narrower than one bit
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_STREAM = 2'd2
    } drain_state_e;

    // Accumulator (DIM-1,DIM-1) sees its last product 3*DIM-2 edges after the
    // first operand; one extra cycle of margin gives 3*DIM-1.
    function automatic int unsigned settle_cycles(input int unsigned dim);
        return 3 * dim - 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/drain_index_counter.sv
// -----------------------------------------------------------------------------
// drain_index_counter
//   Row/column index generator for the result drain. Advances once per
//   accepted element and flags the final element of the matrix.
//   Build option: SYS_DRAIN_COLMAJOR_EN selects column-major order (row index
//   wraps first); default is row-major (column index wraps first).
//
//   Ports
//     clk_i   : clock, rising edge
//     rst_ni  : asynchronous active-low reset
//     clear_i : force index back to (0,0)
//     adv_i   : advance to the next element (handshake)
//     row_o   : current row index
//     col_o   : current column index
//     last_o  : current index is (DIM-1,DIM-1)
// -----------------------------------------------------------------------------
module drain_index_counter
    import systolic_pkg::*;
#(
    parameter int unsigned DIM = 3,
    parameter int unsigned IW  = idx_width(DIM)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          adv_i,
    output logic [IW-1:0] row_o,
    output logic [IW-1:0] col_o,
    output logic          last_o
);

    localparam logic [IW-1:0] MAX_IDX = IW'(DIM - 1);

    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (adv_i) begin
`ifdef SYS_DRAIN_COLMAJOR_EN
            if (row_q == MAX_IDX) begin
                row_d = '0;
                col_d = (col_q == MAX_IDX) ? '0 : col_q + 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
`else
            if (col_q == MAX_IDX) begin
                col_d = '0;
                row_d = (row_q == MAX_IDX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == MAX_IDX) && (col_q == MAX_IDX);

endmodule

// File: rtl/systolic_drain.sv
// -----------------------------------------------------------------------------
// systolic_drain
//   Result reader for systolic_array. Arms on start, waits the settle interval,
//   snapshots the DIM x DIM accumulator bus and streams the elements out with a
//   valid/ready handshake, tagged with row/column indices.
//   Build option: SYS_DRAIN_COLMAJOR_EN streams column-major (see
//   drain_index_counter); default is row-major.
//
//   Ports
//     clock     : clock, rising edge
//     reset     : asynchronous active-low reset
//     start     : one-cycle arm pulse, aligned with a11/b11 at the array
//     result    : flattened accumulator bus, element (0,0) in the MSBs
//     out_data  : current element (2*WIDTH bits)
//     out_row   : row index of out_data
//     out_col   : column index of out_data
//     out_valid : element available
//     out_ready : consumer accepts
//     out_last  : current element is the final one of the matrix
//     busy      : sequencer in SETTLE or STREAM
//     overrun   : sticky, start seen while busy
// -----------------------------------------------------------------------------
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIM   = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [2*DIM*DIM*WIDTH-1:0]   result,
    output logic [2*WIDTH-1:0]           out_data,
    output logic [idx_width(DIM)-1:0]    out_row,
    output logic [idx_width(DIM)-1:0]    out_col,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overrun
);

    localparam int unsigned EW     = 2 * WIDTH;
    localparam int unsigned NEL    = DIM * DIM;
    localparam int unsigned SETTLE = settle_cycles(DIM);
    localparam int unsigned IW     = idx_width(DIM);
    localparam int unsigned CW     = idx_width(SETTLE);

    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);

    drain_state_e          state_q;
    logic [CW-1:0]         cnt_q;
    logic [NEL*EW-1:0]     snap_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  overrun_q;

    logic [IW-1:0]         row;
    logic [IW-1:0]         col;
    logic                  idx_last;
    logic                  hs;
    logic                  arm;
    logic [EW-1:0]         elem_d;

    assign hs  = valid_q && out_ready;
    assign arm = (state_q == ST_IDLE) && start;

    drain_index_counter #(
        .DIM (DIM),
        .IW  (IW)
    ) u_idx (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (arm),
        .adv_i   (hs),
        .row_o   (row),
        .col_o   (col),
        .last_o  (idx_last)
    );

    // Sequencer: busy/valid are registered alongside the state so no output
    // depends combinationally on out_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SETTLE;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_END) begin
                        state_q <= ST_STREAM;
                        valid_q <= 1'b1;
                        snap_q  <= result;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (hs && idx_last) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A start while busy (including the cycle of the final handshake) never
    // re-arms; it only latches this flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else if (start && busy_q) begin
            overrun_q <= 1'b1;
        end
    end

    // Element (r,c) lives at offset EW*(NEL-1-(r*DIM+c)) of the snapshot.
    always_comb begin
        int unsigned idx;
        idx    = int'(row) * DIM + int'(col);
        elem_d = '0;
        if (idx < NEL) begin
            elem_d = snap_q[EW*(NEL-1-idx) +: EW];
        end
    end

    assign out_data  = valid_q ? elem_d : '0;
    assign out_row   = row;
    assign out_col   = col;
    assign out_valid = valid_q;
    assign out_last  = valid_q && idx_last;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_systolic_drain.sv
// -----------------------------------------------------------------------------
// tb_systolic_drain
//   Self-checking bench for systolic_drain (DIM=3, WIDTH=8). Expected elements
//   are queued when a start is driven and compared while out_valid is high;
//   an element is popped only on its handshake.
// -----------------------------------------------------------------------------
module tb_systolic_drain;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIM   = 3;
    localparam int unsigned NEL   = DIM * DIM;
    localparam int unsigned BUSW  = 2 * NEL * WIDTH;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [BUSW-1:0] result = '0;
    logic [15:0]     out_data;
    logic [1:0]      out_row;
    logic [1:0]      out_col;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            out_last;
    logic            busy;
    logic            overrun;

    int unsigned     cmat [NEL] = '{85, 27, 80, 47, 13, 43, 10, 32, 7};
    exp_t            sb [$];
    exp_t            e;
    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    logic            mon_en   = 1'b0;
    logic            bp_mode  = 1'b0;
    int              bp_i     = 0;

    systolic_drain #(
        .WIDTH (WIDTH),
        .DIM   (DIM)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .result    (result),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Ready pattern 1,0,0 repeating when backpressure is enabled.
    always @(posedge clock) begin
        #1;
        if (bp_mode) begin
            out_ready = (bp_i % 3 == 0);
            bp_i++;
        end else begin
            out_ready = 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BUSW-1:0] build_c();
        logic [BUSW-1:0] v;
        v = '0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                v[16*(NEL - r*DIM - c) - 1 -: 16] = 16'(cmat[r*DIM + c]);
        return v;
    endfunction

    task automatic push_matrix();
        exp_t x;
        for (int i = 0; i < NEL; i++) begin
`ifdef SYS_DRAIN_COLMAJOR_EN
            x.row = 2'(i % DIM);
            x.col = 2'(i / DIM);
`else
            x.row = 2'(i / DIM);
            x.col = 2'(i % DIM);
`endif
            x.data = 16'(cmat[int'(x.row) * DIM + int'(x.col)]);
            x.last = (i == NEL - 1);
            sb.push_back(x);
        end
    endtask

    // Drives a one-cycle start; k is the count of the edge that samples it.
    task automatic pulse_start(input bit expect_stream, output int k);
        @(posedge clock);
        #1;
        start = 1'b1;
        if (expect_stream) push_matrix();
        @(posedge clock);
        #1;
        k = cyc;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int c);
        c = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (out_valid) begin
                c = cyc;
                return;
            end
        end
        check_val("wait_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle(input int limit, output int c);
        c = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (!busy) begin
                c = cyc;
                return;
            end
        end
        check_val("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    // Scoreboard monitor: compares the queue head while valid, pops on handshake.
    always @(negedge clock) begin
        if (reset && mon_en) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb[0];
                    check_val("data", 32'(out_data), 32'(e.data));
                    check_val("row",  32'(out_row),  32'(e.row));
                    check_val("col",  32'(out_col),  32'(e.col));
                    check_val("last", 32'(out_last), 32'(e.last));
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                check_val("last_without_valid", 32'(out_last), 32'd0);
            end
        end
    end

    initial begin
        int k;
        int c;

        result = build_c();

        // Reset state
        #12;
        check_val("rst_valid",   32'(out_valid), 32'd0);
        check_val("rst_busy",    32'(busy),      32'd0);
        check_val("rst_overrun", 32'(overrun),   32'd0);
        check_val("rst_data",    32'(out_data),  32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clock);
        check_val("idle_no_valid", 32'(out_valid), 32'd0);

        // Nominal stream with latency checks
        pulse_start(1'b1, k);
        @(negedge clock);
        check_val("busy_after_start", 32'(busy), 32'd1);
        check_val("valid_during_settle", 32'(out_valid), 32'd0);
        wait_valid(40, c);
        check_val("valid_latency", 32'(c - k), 32'd8);
        wait_idle(40, c);
        check_val("idle_latency", 32'(c - k), 32'd17);
        check_val("valid_low_at_idle", 32'(out_valid), 32'd0);
        check_val("sb_drained_nominal", 32'(sb.size()), 32'd0);

        // Backpressure
        bp_mode = 1'b1;
        bp_i = 0;
        pulse_start(1'b1, k);
        wait_idle(200, c);
        bp_mode = 1'b0;
        check_val("sb_drained_bp", 32'(sb.size()), 32'd0);

        // Snapshot isolation
        pulse_start(1'b1, k);
        wait_valid(40, c);
        @(posedge clock);
        #1;
        result = '1;
        wait_idle(40, c);
        result = build_c();
        check_val("sb_drained_snap", 32'(sb.size()), 32'd0);

        // Reset mid-stream: outputs clear immediately, nothing resumes
        pulse_start(1'b1, k);
        wait_valid(40, c);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        sb.delete();
        check_val("midrst_valid", 32'(out_valid), 32'd0);
        check_val("midrst_busy",  32'(busy),      32'd0);
        check_val("midrst_data",  32'(out_data),  32'd0);
        check_val("midrst_row",   32'(out_row),   32'd0);
        check_val("midrst_col",   32'(out_col),   32'd0);
        check_val("midrst_last",  32'(out_last),  32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (12) @(negedge clock);
        check_val("post_rst_valid", 32'(out_valid), 32'd0);
        check_val("post_rst_busy",  32'(busy),      32'd0);

        // Overrun: second start during STREAM
        pulse_start(1'b1, k);
        wait_valid(40, c);
        check_val("overrun_before", 32'(overrun), 32'd0);
        pulse_start(1'b0, k);
        @(negedge clock);
        check_val("overrun_set", 32'(overrun), 32'd1);
        wait_idle(40, c);
        repeat (20) @(negedge clock);
        check_val("overrun_sticky", 32'(overrun), 32'd1);
        check_val("no_second_stream", 32'(busy), 32'd0);
        check_val("sb_drained_overrun", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Result reader for the `systolic_array` matrix multiplier.
- Arms on a `start` pulse issued in the same cycle the operand feeder presents a11/b11.
- Waits a fixed settle interval, then snapshots the DIM×DIM accumulator bus.
- Streams the elements out one per handshake with valid/ready, tagged with row/column indices.
- Sits between the array's `result` port and any downstream consumer (bus bridge, FIFO, checker).

## Interface
- `WIDTH`, default 8: operand width; each result element is 2*WIDTH bits.
- `DIM`, default 3: array dimension; DIM*DIM elements per matrix.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low; all state cleared while low.
- `start`  in  1: arm pulse, one cycle.
- `result`  in  2*DIM*DIM*WIDTH: flattened accumulator bus. Element (r,c) is at bits [2*WIDTH*(DIM*DIM - r*DIM - c) - 1 -: 2*WIDTH], so (0,0) occupies the MSBs.
- `out_data`  out  2*WIDTH: current element.
- `out_row`, `out_col`  out  $clog2(DIM) each: indices of `out_data`.
- `out_valid`  out  1: element available.
- `out_ready`  in  1: consumer accepts.
- `out_last`  out  1: current element is the final one of the matrix.
- `busy`  out  1: high in SETTLE or STREAM.
- `overrun`  out  1: sticky; set by `start` while busy; cleared only by reset.

## Operation
- **States:**
  - IDLE → SETTLE on `start`.
  - SETTLE → STREAM when the settle counter reaches SETTLE-1.
  - STREAM → IDLE on the handshake of the last element.
- **SETTLE** = 3*DIM-1 cycles. Accumulator (DIM-1,DIM-1) takes its last product 3*DIM-2 edges after the first operand; the extra cycle is margin.
- **Capture:** on the SETTLE→STREAM edge, the whole `result` bus is copied into a local snapshot. Later `result` changes do not affect the stream.
- **Order:** row-major by default: (0,0),(0,1),…,(DIM-1,DIM-1).
- **Indexing:** the index counter advances only on `out_valid && out_ready`. The column wraps DIM-1 → 0 and increments the row.
- **`out_last`:** high exactly when the current index is the final element and `out_valid` is high.
- **Stability:** while `out_valid && !out_ready`, `out_data`, `out_row`, `out_col` and `out_last` hold stable.
- **`start` while busy:** ignored for sequencing and sets `overrun`; the current matrix completes normally.
- **`start` in the same cycle as the final handshake:** the block is still busy, so the start is treated as an overrun; it does not re-arm.
- **Reset mid-operation:** returns to IDLE immediately. The snapshot is zeroed and no partial stream resumes.
- **Arithmetic:** elements pass through unmodified at 2*WIDTH bits; no truncation and no sign handling.

## Timing
- **Reset values:** `out_data`, `out_row`, `out_col`, `out_valid`, `out_last`, `busy`, `overrun` all 0.
- **Start:** `start` sampled high at edge k → `busy` high after edge k.
- **Snapshot:** taken at edge k+SETTLE; `out_valid` is high from after that edge.
- **Throughput:** with `out_ready` held high, one element per cycle. The last handshake occurs at edge k+SETTLE+DIM*DIM.
- **Return to idle:** after the last handshake, `out_valid` and `busy` are low in the next cycle.
- **Minimum spacing** between accepted starts: SETTLE+DIM*DIM+1 cycles.
- **Combinational paths:** `out_ready` has no combinational path to any output.

## Configuration
- **`SYS_DRAIN_COLMAJOR_EN` defined:** stream order is column-major, (0,0),(1,0),…,(DIM-1,DIM-1). The row index wraps and increments the column; `out_last` stays on (DIM-1,DIM-1).
- **Not defined:** row-major as above.
- Timing, handshake and element count are identical in both modes.

## Structure
- **Package `systolic_pkg`:**
  - state enum (IDLE, SETTLE, STREAM);
  - `settle_cycles(DIM)` function returning 3*DIM-1;
  - element index width helper.
- **Sub-module `drain_index_counter`:** row/col counter with the handshake enable, the macro-selected wrap order, and the last-element flag.
- The top level holds the FSM, the settle counter and the snapshot register.

## Test plan
All scenarios use DIM=3, WIDTH=8. The bench drives `result` with C = [[85,27,80],[47,13,43],[10,32,7]].
- **Reset values:** assert `reset` low mid-run → all outputs 0 immediately. Release → IDLE; `out_valid` stays 0 without `start`.
- **Nominal stream:** `start` at edge k, `out_ready`=1 → `out_valid` rises after edge k+8. Data is 85,27,80,47,13,43,10,32,7 with matching row/col; `out_last` only on 7; `busy` low after edge k+17.
- **Backpressure:** `out_ready` toggles 1,0,0,1,… → each element holds stable while stalled; all nine delivered exactly once in order.
- **Snapshot isolation:** change `result` to all 0xFFFF one cycle after capture → the stream still emits the original C values.
- **Overrun:** second `start` during STREAM → `overrun`=1 and stays 1; the stream is unaffected; no second stream follows.
- **Column-major build** (`SYS_DRAIN_COLMAJOR_EN`): nominal stimulus → 85,47,10,27,13,32,80,43,7; `out_last` on 7.
